// File: rtl/macc_pkg.sv
// Shared types and constants for the MACC multiplier path.
package macc_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'b00,
      BOOTH_ADD = 2'b01,
      BOOTH_SUB = 2'b10
   } booth_op_t;

   function automatic booth_op_t booth_dec(input logic q0, input logic qm1);
      booth_op_t op;
      unique case ({q0, qm1})
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Ripple-carry adder/subtractor; sub inverts B and feeds the carry-in.
module addsub_nbit #(
   parameter int W = 5
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         sub,
   output logic [W-1:0] S,
   output logic         cout
);

   logic [W:0]   c;
   logic [W-1:0] bx;

   assign c[0] = sub;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign bx[i]   = B[i] ^ sub;
      assign S[i]    = A[i] ^ bx[i] ^ c[i];
      assign c[i+1]  = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
   end

   assign cout = c[W];

endmodule

// File: rtl/booth_seq_mac_ctrl.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides.
module booth_seq_mac_ctrl
   import macc_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int CW = $clog2(N) + 1;

   state_t         state_q, state_d;
   logic [N:0]     mext_q, mext_d;
   logic [N:0]     acc_q, acc_d;
   logic [N-1:0]   qreg_q, qreg_d;
   logic           qm1_q, qm1_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] prod_q, prod_d;
   logic           ov_q, ov_d;

   booth_op_t  op;
   logic       sub;
   logic [N:0] addsub_s;
   logic [N:0] sum;
   logic       unused_cout;

   assign op  = booth_dec(qreg_q[0], qm1_q);
   assign sub = (op == BOOTH_SUB);
   assign sum = (op == BOOTH_NOP) ? acc_q : addsub_s;

   addsub_nbit #(.W(N + 1)) u_addsub (
      .A    (acc_q),
      .B    (mext_q),
      .sub  (sub),
      .S    (addsub_s),
      .cout (unused_cout)
   );

   always_comb begin
      state_d = state_q;
      mext_d  = mext_q;
      acc_d   = acc_q;
      qreg_d  = qreg_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mext_d  = {multiplicand[N-1], multiplicand};
               qreg_d  = multiplier;
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // arithmetic shift of {sum, q_reg, q_m1}
            acc_d  = {sum[N], sum[N:1]};
            qreg_d = {sum[0], qreg_q[N-1:1]};
            qm1_d  = qreg_q[0];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = DONE;
         end
         DONE: begin
            if (ov_q && out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end else begin
               ov_d   = 1'b1;
               prod_d = {acc_q[N-1:0], qreg_q};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mext_q  <= '0;
         acc_q   <= '0;
         qreg_q  <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mext_q  <= mext_d;
         acc_q   <= acc_d;
         qreg_q  <= qreg_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == CALC) || (state_q == DONE);
   assign out_valid = ov_q;
   assign product   = prod_q;

endmodule
